// File: rtl/pwm_spi_pkg.sv
// -----------------------------------------------------------------------------
// pwm_spi_pkg
// Shared definitions for the SPI side of the PWM generator.
//   ADDR_W / DATA_W   : register address width and SPI byte width
//   CMD_W_BIT         : command byte bit selecting write (1) or read (0)
//   CMD_HI_BIT        : command byte bit selecting the high byte lane
//   state_e           : command decoder FSM state encoding
// -----------------------------------------------------------------------------
package pwm_spi_pkg;

    localparam int ADDR_W     = 6;
    localparam int DATA_W     = 8;
    localparam int CMD_W_BIT  = 7;
    localparam int CMD_HI_BIT = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CMD_RD    = 2'd1,
        WAIT_DATA = 2'd2,
        WR        = 2'd3
    } state_e;

endpackage

// File: rtl/edge_pulse.sv
// -----------------------------------------------------------------------------
// edge_pulse
// Rising-edge detector for a strobe that is already synchronised to clk.
// A level held high for many cycles produces a single one-cycle pulse.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   sig_in : synchronised level input
//   pulse  : high in the first cycle sig_in is seen high after being low
// -----------------------------------------------------------------------------
module edge_pulse (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic pulse
);

    logic sig_d;
    logic sig_q;

    // Next value of the delayed copy is simply the current input.
    always_comb begin
        sig_d = sig_in;
    end

    // Delayed copy of the input used as the "previous" level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign pulse = sig_in & ~sig_q;

endmodule

// File: rtl/spi_instr_decoder.sv
// -----------------------------------------------------------------------------
// spi_instr_decoder
// Parses bytes from the SPI bridge into two-byte register transactions:
// a command byte {W, hi_sel, addr[5:0]} followed by a data byte. Writes
// strobe `write` with the data byte; reads strobe `read` right after the
// command and hand the register value to the bridge on data_out so it is
// shifted out during the (dummy) second byte.
//   clk, rst    : system clock, synchronous active-high reset
//   byte_sync   : byte-complete level from the bridge (edge = one byte)
//   cs_n        : chip select, high aborts the frame and clears data_out
//   data_in     : received byte, stable while byte_sync is high
//   data_out    : byte returned to the bridge
//   read/write  : single-cycle register strobes
//   addr/hi_sel : register address and byte lane from the command byte
//   data_write  : write data, valid with write
//   data_read   : combinational register read data, valid with read
// -----------------------------------------------------------------------------
module spi_instr_decoder
    import pwm_spi_pkg::*;
#(
    parameter int ADDR_W = pwm_spi_pkg::ADDR_W,
    parameter int DATA_W = pwm_spi_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_sync,
    input  logic              cs_n,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    output logic              hi_sel,
    output logic [DATA_W-1:0] data_write,
    input  logic [DATA_W-1:0] data_read
);

    logic              byte_ev;

    state_e            state_d,      state_q;
    logic              read_d,       read_q;
    logic              write_d,      write_q;
    logic [ADDR_W-1:0] addr_d,       addr_q;
    logic              hi_sel_d,     hi_sel_q;
    logic              w_d,          w_q;
    logic [DATA_W-1:0] data_write_d, data_write_q;
    logic [DATA_W-1:0] data_out_d,   data_out_q;

    edge_pulse u_byte_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_in (byte_sync),
        .pulse  (byte_ev)
    );

    // Next-state, capture and strobe logic. Strobes are registered, so a
    // strobe is requested here in the cycle before it appears on the port.
    always_comb begin
        state_d      = state_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        addr_d       = addr_q;
        hi_sel_d     = hi_sel_q;
        w_d          = w_q;
        data_write_d = data_write_q;
        data_out_d   = data_out_q;

        if (cs_n) begin
            // Frame idle/aborted: drop any byte seen this cycle.
            state_d    = IDLE;
            data_out_d = {DATA_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (byte_ev) begin
                        addr_d   = data_in[ADDR_W-1:0];
                        hi_sel_d = data_in[CMD_HI_BIT];
                        w_d      = data_in[CMD_W_BIT];
                        if (data_in[CMD_W_BIT]) begin
                            state_d = WAIT_DATA;
                        end else begin
                            state_d = CMD_RD;
                            read_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CMD_RD: begin
                    // read is high this cycle, so data_read belongs to addr.
                    data_out_d = data_read;
                    state_d    = WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (byte_ev) begin
                        if (w_q) begin
                            data_write_d = data_in;
                            write_d      = 1'b1;
                            state_d      = WR;
                        end else begin
                            // Second byte of a read is a dummy.
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = WAIT_DATA;
                    end
                end
                WR: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            hi_sel_q     <= 1'b0;
            w_q          <= 1'b0;
            data_write_q <= {DATA_W{1'b0}};
            data_out_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            hi_sel_q     <= hi_sel_d;
            w_q          <= w_d;
            data_write_q <= data_write_d;
            data_out_q   <= data_out_d;
        end
    end

    assign read       = read_q;
    assign write      = write_q;
    assign addr       = addr_q;
    assign hi_sel     = hi_sel_q;
    assign data_write = data_write_q;
    assign data_out   = data_out_q;

endmodule

// File: tb/tb_spi_instr_decoder.sv
// -----------------------------------------------------------------------------
// tb_spi_instr_decoder
// Drives byte streams into spi_instr_decoder and compares every cycle with a
// transaction-level model: a command byte is remembered until its data byte
// arrives; cs_n high forgets it. Directed sequences pin the model and the
// DUT to hand-computed values, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_spi_instr_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_sync;
    logic       cs_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic       hi_sel;
    logic [7:0] data_write;
    logic [7:0] data_read;

    // Register file contents, indexed by {hi_sel, addr}.
    logic [7:0] regfile [0:127];

    always #5 clk = ~clk;

    assign data_read = regfile[{hi_sel, addr}];

    spi_instr_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .byte_sync  (byte_sync),
        .cs_n       (cs_n),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .hi_sel     (hi_sel),
        .data_write (data_write),
        .data_read  (data_read)
    );

    // Model state
    logic       m_have_cmd = 1'b0;
    logic       m_w        = 1'b0;
    logic       m_prev_bs  = 1'b0;
    logic       exp_read   = 1'b0, nxt_read;
    logic       exp_write  = 1'b0, nxt_write;
    logic [5:0] exp_addr   = 6'd0, nxt_addr;
    logic       exp_hi     = 1'b0, nxt_hi;
    logic [7:0] exp_dw     = 8'h00, nxt_dw;
    logic [7:0] exp_dout   = 8'h00, nxt_dout;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_en   = 1'b0;
    bit          pin_en   = 1'b0;
    logic [24:0] pin_val  = 25'd0;
    logic [24:0] pin_mask = 25'd0;
    string       pin_name = "";

    localparam logic [24:0] FULL    = 25'h1FFFFFF;
    localparam logic [24:0] NO_DOUT = 25'h1FFFF00;

    function automatic logic [24:0] pk(input logic r, input logic w,
                                       input logic [5:0] a, input logic h,
                                       input logic [7:0] dw, input logic [7:0] dout);
        return {r, w, a, h, dw, dout};
    endfunction

    // Apply one cycle of inputs, predict the outputs after the edge.
    task automatic step(input logic r, input logic c, input logic bs, input logic [7:0] d);
        logic ev;
        rst       = r;
        cs_n      = c;
        byte_sync = bs;
        data_in   = d;
        nxt_read  = 1'b0;
        nxt_write = 1'b0;
        nxt_addr  = exp_addr;
        nxt_hi    = exp_hi;
        nxt_dw    = exp_dw;
        nxt_dout  = exp_dout;
        if (r) begin
            nxt_addr   = 6'd0;
            nxt_hi     = 1'b0;
            nxt_dw     = 8'h00;
            nxt_dout   = 8'h00;
            m_have_cmd = 1'b0;
            m_w        = 1'b0;
            m_prev_bs  = 1'b0;
        end else begin
            ev        = bs & ~m_prev_bs;
            m_prev_bs = bs;
            if (c) nxt_dout = 8'h00;
            else if (exp_read) nxt_dout = regfile[{exp_hi, exp_addr}];
            if (c) begin
                m_have_cmd = 1'b0;
            end else if (ev) begin
                if (!m_have_cmd) begin
                    m_w        = d[7];
                    nxt_hi     = d[6];
                    nxt_addr   = d[5:0];
                    nxt_read   = ~d[7];
                    m_have_cmd = 1'b1;
                end else begin
                    if (m_w) begin
                        nxt_write = 1'b1;
                        nxt_dw    = d;
                    end
                    m_have_cmd = 1'b0;
                end
            end
        end
        @(posedge clk);
        pin_en    = 1'b0;
        exp_read  = nxt_read;
        exp_write = nxt_write;
        exp_addr  = nxt_addr;
        exp_hi    = nxt_hi;
        exp_dw    = nxt_dw;
        exp_dout  = nxt_dout;
        cyc++;
        #1;
    endtask

    task automatic pin(input string nm, input logic [24:0] v, input logic [24:0] m);
        pin_name = nm;
        pin_val  = v;
        pin_mask = m;
        pin_en   = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Single compare process: model every cycle, literal pins when armed.
    always @(negedge clk) begin
        logic [24:0] dv;
        logic [24:0] ev;
        if (chk_en) begin
            dv = {read, write, addr, hi_sel, data_write, data_out};
            ev = {exp_read, exp_write, exp_addr, exp_hi, exp_dw, exp_dout};
            n_checks++;
            if (dv !== ev) begin
                n_fail++;
                $display("FAIL model_cmp cycle %0d: dut=%h expected=%h", cyc, dv, ev);
            end
            n_checks++;
            if ((read & write) !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_wr_excl cycle %0d: read=%b write=%b", cyc, read, write);
            end
            if (pin_en) begin
                n_checks++;
                if (((dv ^ pin_val) & pin_mask) !== 25'd0) begin
                    n_fail++;
                    $display("FAIL pin_dut %s cycle %0d: dut=%h required=%h mask=%h",
                             pin_name, cyc, dv, pin_val, pin_mask);
                end
                n_checks++;
                if (((ev ^ pin_val) & pin_mask) !== 25'd0) begin
                    n_fail++;
                    $display("FAIL pin_model %s cycle %0d: model=%h required=%h mask=%h",
                             pin_name, cyc, ev, pin_val, pin_mask);
                end
            end
        end
    end

    initial begin
        int hold;
        int low;
        logic [7:0] b;

        for (int i = 0; i < 128; i++) regfile[i] = 8'($urandom);
        regfile[7'h43] = 8'h5C;
        regfile[7'h04] = 8'h3C;

        rst = 1'b1; cs_n = 1'b1; byte_sync = 1'b0; data_in = 8'h00;
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        pin("reset", pk(1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 8'h00), FULL);
        idle(2);

        // Write 0x85, 0xA5
        step(1'b0, 1'b0, 1'b1, 8'h85);
        pin("wr_cmd", pk(1'b0, 1'b0, 6'd5, 1'b0, 8'h00, 8'h00), FULL);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 8'hA5);
        pin("wr_strobe", pk(1'b0, 1'b1, 6'd5, 1'b0, 8'hA5, 8'h00), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        pin("wr_done", pk(1'b0, 1'b0, 6'd5, 1'b0, 8'hA5, 8'h00), FULL);
        idle(2);

        // Read 0x43 with data_read 0x5C, dummy 0x00
        step(1'b0, 1'b0, 1'b1, 8'h43);
        pin("rd_strobe", pk(1'b1, 1'b0, 6'd3, 1'b1, 8'hA5, 8'h00), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        pin("rd_data", pk(1'b0, 1'b0, 6'd3, 1'b1, 8'hA5, 8'h5C), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        pin("rd_dummy", pk(1'b0, 1'b0, 6'd3, 1'b1, 8'hA5, 8'h5C), FULL);
        idle(3);

        // Held byte_sync carrying 0x81, then 0x11
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h81);
            if (i == 0) pin("hold_cmd", pk(1'b0, 1'b0, 6'd1, 1'b0, 8'hA5, 8'h5C), FULL);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        pin("hold_wr", pk(1'b0, 1'b1, 6'd1, 1'b0, 8'h11, 8'h5C), FULL);
        idle(3);

        // Abort after 0x82, then read command 0x04 and dummy
        step(1'b0, 1'b0, 1'b1, 8'h82);
        pin("abort_cmd", pk(1'b0, 1'b0, 6'd2, 1'b0, 8'h11, 8'h5C), FULL);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        pin("abort_clr", pk(1'b0, 1'b0, 6'd2, 1'b0, 8'h11, 8'h00), FULL);
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h04);
        pin("abort_rd", pk(1'b1, 1'b0, 6'd4, 1'b0, 8'h11, 8'h00), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        pin("abort_rdata", pk(1'b0, 1'b0, 6'd4, 1'b0, 8'h11, 8'h3C), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        pin("abort_nowr", pk(1'b0, 1'b0, 6'd4, 1'b0, 8'h11, 8'h3C), FULL);
        idle(3);

        // Collision: cs_n rises with the data byte event
        step(1'b0, 1'b0, 1'b1, 8'h90);
        pin("coll_cmd", pk(1'b0, 1'b0, 6'h10, 1'b0, 8'h11, 8'h3C), FULL);
        idle(2);
        step(1'b0, 1'b1, 1'b1, 8'h77);
        pin("coll", pk(1'b0, 1'b0, 6'h10, 1'b0, 8'h11, 8'h00), FULL);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 8'h06);
        pin("coll_idle", pk(1'b1, 1'b0, 6'd6, 1'b0, 8'h11, 8'h00), FULL);
        idle(2);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        idle(3);

        // Reset mid-transaction after 0x9F, then 0x33 as a command
        step(1'b0, 1'b0, 1'b1, 8'h9F);
        pin("rst_cmd", pk(1'b0, 1'b0, 6'h1F, 1'b0, 8'h11, 8'h00), NO_DOUT);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        pin("rst_mid", pk(1'b0, 1'b0, 6'd0, 1'b0, 8'h00, 8'h00), FULL);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h33);
        pin("rst_next", pk(1'b1, 1'b0, 6'h33, 1'b0, 8'h00, 8'h00), FULL);
        idle(4);

        // Randomized traffic
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 59) == 0) begin
                step(1'b1, 1'b0, 1'b0, 8'h00);
                step(1'b0, 1'b0, 1'b0, 8'h00);
            end
            hold = $urandom_range(1, 4);
            low  = $urandom_range(0, 3) + ((hold >= 3) ? 1 : (3 - hold));
            b    = 8'($urandom);
            for (int h = 0; h < hold; h++)
                step(1'b0, ($urandom_range(0, 24) == 0), 1'b1, b);
            for (int l = 0; l < low; l++)
                step(1'b0, ($urandom_range(0, 24) == 0), 1'b0, 8'($urandom));
        end
        idle(3);

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_instr_decoder.md
# spi_instr_decoder

Command decoder directly downstream of the SPI bridge in the PWM generator. It consumes the bridge's received bytes (`data_in` qualified by `byte_sync`) and parses them into two-byte register transactions: a command byte, then a data byte. It issues single-cycle read/write strobes toward the register file and returns read data to the bridge's `data_out` for shifting on the next byte.

## Interface
Parameters:
- ADDR_W, 6, register address width (command byte bits [5:0])
- DATA_W, 8, data byte width; fixed at 8 by the SPI byte framing

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- byte_sync  input  1  bridge byte-complete flag, synchronised to clk; may stay high for several clk cycles per byte
- cs_n  input  1  SPI chip select, synchronised to clk; high = frame idle/aborted
- data_in  input  8  received byte from bridge; stable while byte_sync high
- data_out  output  8  byte returned to bridge for transmission
- read  output  1  single-cycle register read strobe
- write  output  1  single-cycle register write strobe
- addr  output  6  register address, held from command capture until the next command
- hi_sel  output  1  byte-lane select (1 = high byte of a 16-bit register)
- data_write  output  8  write data, valid with `write`
- data_read  input  8  register read data; combinational, valid in the same cycle as `read`

## Operation
- Byte event: rising edge of `byte_sync` (`byte_sync & ~sync_q`). Holding `byte_sync` high gives exactly one event.
- Command byte format:
  - bit7 = W (1 write, 0 read)
  - bit6 = hi_sel
  - bits[5:0] = addr
- FSM states:
  - IDLE: waiting for command.
  - CMD_RD: one cycle; asserts `read` and captures `data_read` into `data_out`.
  - WAIT_DATA: waiting for the second byte.
  - WR: one cycle; asserts `write`.
- Transitions:
  - IDLE + event, W=0 → CMD_RD.
  - CMD_RD → WAIT_DATA (unconditional).
  - IDLE + event, W=1 → WAIT_DATA.
  - WAIT_DATA + event → WR if the captured W=1, else IDLE. For a read, the second byte is a dummy and is discarded.
  - WR → IDLE.
- On an event in IDLE, `addr`, `hi_sel` and W are registered from `data_in`.
- On an event in WAIT_DATA with W=1, `data_write` is registered from `data_in`.
- `cs_n` high: FSM returns to IDLE next cycle. Any pending strobe for that cycle is suppressed and `data_out` clears to 0x00.
- `cs_n` high in the same cycle as an event: `cs_n` wins and the byte is discarded.
- After a read completes, `data_out` holds its value until the next read or `cs_n` high.

## Timing
- Reset values:
  - read = 0, write = 0
  - addr = 0, hi_sel = 0
  - data_write = 0x00, data_out = 0x00
  - sync_q = 0, state = IDLE
- `rst` asserted mid-transaction: all of the above take effect next edge, and the partial transaction is dropped.
- Let E be the cycle in which the event is detected.
- Command event at E: `addr`/`hi_sel` valid at E+1.
- Read: `read` high for exactly E+1. `data_out` equals `data_read` from E+2.
- Write, with the data event at E2: `write` high for exactly E2+1, with `addr`, `hi_sel` and `data_write` stable in that cycle.
- Minimum spacing between events: 3 clk. The bridge's 8 sclk per byte guarantees this whenever clk ≥ sclk.
- `read` and `write` are never high in the same cycle.

## Structure
- Shared package `pwm_spi_pkg`:
  - command bit positions CMD_W_BIT = 7, CMD_HI_BIT = 6.
  - ADDR_W, and the FSM state encoding (IDLE, CMD_RD, WAIT_DATA, WR).
- Sub-module `edge_pulse`: `byte_sync` rising-edge detector with one register and a synchronous active-high reset. It is reused for other synchronised strobes.
- The remaining logic (FSM and capture registers) lives in the top module.

## Test plan
- Write: events 0x85 then 0xA5 → one `write` pulse with addr = 5, hi_sel = 0, data_write = 0xA5; no `read`.
- Read: event 0x43 with data_read = 0x5C → `read` pulse at E+1 with addr = 3, hi_sel = 1; data_out = 0x5C from E+2. A following dummy byte 0x00 gives no `write`, and the FSM returns to IDLE.
- Held `byte_sync`: high for 5 cycles carrying 0x81 → exactly one command capture. The next event 0x11 writes 0x11 to addr 1.
- Abort: 0x82 then `cs_n` high for 2 cycles, then `cs_n` low and events 0x04, 0x00 → no `write` to addr 2. 0x04 is decoded as a read command for addr 4.
- Collision: `cs_n` rises in the event cycle of the data byte → no `write`; state is IDLE and data_out = 0x00.
- Reset mid-op: `rst` pulsed in WAIT_DATA after 0x9F → all outputs at reset values. The next byte 0x33 is treated as a command: a read of addr 0x33, hi_sel = 0.
